display_mux_n_digit: RTL and testbench
======================================

Name: display_mux_n_digit

Overview:
Parametrised successor to the 4-digit multiplexed 7-segment driver. Time-multiplexes N_DIGITS hex/BCD digits onto one shared active-low segment bus with 1-cold anodes. Adds:
- a double-buffered digit load
- per-digit decimal points
- leading-zero blanking
- PWM brightness control
- a global display enable
- fully registered, glitch-free outputs
Sits between datapath blocks (sorters, counters) and the board's 7-segment display.

Parameters:
N_DIGITS, 4, number of digits/anodes; legal range 1..8
DIV_BITS, 14, prescaler width; each digit slot lasts 2^DIV_BITS clk cycles
BRIGHT_BITS, 3, brightness control width; must be <= DIV_BITS

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
bcd  in  4*N_DIGITS  digit values; digit i = bcd[4i+3:4i]; digit 0 is rightmost/least significant
dp  in  N_DIGITS  decimal-point request per digit, 1 = lit
load  in  1  1-cycle strobe; captures bcd and dp into shadow registers
blank_lz  in  1  1 = blank leading zeros
brightness  in  BRIGHT_BITS  duty control; all-ones = 100 %
disp_en  in  1  0 = all anodes off
seg  out  8  {a,b,c,d,e,f,g,dp}, active low, registered
an  out  N_DIGITS  1-cold anode select, registered

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - prescaler = 0, digit index = 0
  - shadow bcd = 0, shadow dp = 0
  - an = all ones, seg = 8'hFF
- Shadow load:
  - On clk with load=1, shadow regs take bcd/dp.
  - The display uses only the shadow regs, so a new value appears atomically.
  - With load held high, the shadow regs update every cycle.
- Prescaler:
  - DIV_BITS-bit free-running counter, increments every clk.
  - On wrap from all-ones to 0, the digit index advances. If index = N_DIGITS-1 it wraps to 0.
  - N_DIGITS=1 keeps index at 0.
- Brightness:
  - Slot phase p = top BRIGHT_BITS bits of the prescaler.
  - Anode is active while p <= brightness, i.e. duty = (brightness+1)/2^BRIGHT_BITS.
  - brightness = 0 gives the minimum nonzero duty; the display is never fully dark via brightness.
- Blanking, leading zeros:
  - Digit i (i >= 1) is blanked when blank_lz=1 and shadow digits i..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives segments a–g off; its dp still follows shadow dp.
  - If every segment and the dp would be dark, an stays active. This is harmless and removes a special case.
- Encoding (seg[7:1] = a..g, active low; seg[0] = ~dp):
  - Base values with dp off: 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 A=11 b=C1 c=E5 d=85 E=61 F=71 (hex).
  - dp lit clears bit 0.
- Outputs:
  - an and seg are registered together from the current index/phase/shadow state.
  - Latency is 1 clk from the index/phase change, with no combinational glitch between an and seg.
  - Inactive phase or disp_en=0: an = all ones, seg = 8'hFF.
- disp_en:
  - Does not stop the prescaler or index; re-enable resumes mid-scan.
- Reset mid-scan: the next cycle is the reset state, and the scan restarts at digit 0 with a full slot.

Test Plan:
1. Reset/idle, N_DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2: reset 2 cycles -> an=4'b1111, seg=8'hFF. Release reset, no load -> digit 0 shows seg=8'h03, an=4'b1110 from cycle 1 after release.
2. Scan order: load bcd=16'h4321, dp=0, brightness=3 -> an steps 1110,1101,1011,0111 every 16 clk with seg 9F,25,0D,99. Wraps back to 1110 after 64 clk.
3. Double-buffering and dp: mid-slot, change bcd with load=0 -> seg unchanged. Pulse load with bcd=16'h00A5, dp=4'b0010 -> digit 1 shows seg=8'h11-1 = 8'h10, digit 0 shows 8'h49.
4. Leading-zero blanking: shadow bcd=16'h0070, blank_lz=1 -> digits 3 and 2 show seg=8'hFF, digit 1 shows 8'h1F, digit 0 shows 8'h03. Shadow bcd=16'h0000 -> only digit 0 shows 8'h03.
5. Brightness: brightness=0 -> each anode is active for 4 of 16 slot cycles. brightness=2 -> 12 of 16. disp_en=0 -> an=4'b1111 throughout.
6. Reset mid-slot while on digit 2 -> next cycle an=1111, seg=FF, shadow cleared. Scan restarts at digit 0 showing 8'h03.

Source files
------------

// File: rtl/display_mux_n_digit.sv
// -----------------------------------------------------------------------------
// display_mux_n_digit
//
// Time-multiplexes N_DIGITS hex digits onto one shared active-low 7-segment
// bus with 1-cold anodes. Each digit owns a slot of 2^DIV_BITS clk cycles.
// A shadow copy of bcd/dp is taken on load so a new value appears on the
// display atomically. Leading-zero blanking, per-digit decimal points, PWM
// brightness inside each slot and a global enable are supported. an and seg
// are produced by the same register stage, so they never glitch against each
// other.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; wins over every other input
//   bcd        in   4*N_DIGITS digit values, digit i = bcd[4i+3:4i], digit 0
//                   is the rightmost
//   dp         in   N_DIGITS decimal-point requests, 1 = lit
//   load       in   strobe; copies bcd/dp into the shadow registers
//   blank_lz   in   1 = blank leading zeros (digit 0 is never blanked)
//   brightness in   BRIGHT_BITS duty control, all-ones = 100 %
//   disp_en    in   0 = all anodes off (scan keeps running)
//   seg        out  {a,b,c,d,e,f,g,dp}, active low, registered
//   an         out  N_DIGITS 1-cold anode select, registered
// -----------------------------------------------------------------------------
module display_mux_n_digit #(
  parameter int N_DIGITS    = 4,
  parameter int DIV_BITS    = 14,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4*N_DIGITS-1:0]    bcd,
  input  logic [N_DIGITS-1:0]      dp,
  input  logic                     load,
  input  logic                     blank_lz,
  input  logic [BRIGHT_BITS-1:0]   brightness,
  input  logic                     disp_en,
  output logic [7:0]               seg,
  output logic [N_DIGITS-1:0]      an
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DIV_BITS-1:0]    r_presc;
  logic [IDX_W-1:0]       r_idx;
  logic [4*N_DIGITS-1:0]  r_sh_bcd;
  logic [N_DIGITS-1:0]    r_sh_dp;
  logic [7:0]             r_seg;
  logic [N_DIGITS-1:0]    r_an;

  logic [BRIGHT_BITS-1:0] w_phase;
  logic                   w_active;
  logic                   w_zero_run;
  logic [N_DIGITS-1:0]    w_blank;
  logic [N_DIGITS-1:0]    w_an_sel;
  logic [3:0]             w_digit;
  logic                   w_dp;
  logic                   w_blank_cur;
  logic [7:0]             w_base;
  logic [7:0]             w_seg;

  // Segment pattern with the decimal point off; bit 0 is always 1 here.
  function automatic logic [7:0] seg_base(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'hE5;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // PWM: the top bits of the prescaler give the phase within the slot.
  // brightness = 0 still leaves phase 0 lit, so the display never goes dark.
  assign w_phase  = r_presc[DIV_BITS-1 -: BRIGHT_BITS];
  assign w_active = (w_phase <= brightness);

  // Leading-zero detection runs from the most significant digit downwards:
  // a digit is blanked while every digit at or above it is zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_sh_bcd[4*i +: 4] == 4'h0);
      w_blank[i] = blank_lz && w_zero_run && (i != 0);
    end
  end

  // Select the digit owned by the current slot.
  always_comb begin
    w_an_sel    = '0;
    w_digit     = 4'h0;
    w_dp        = 1'b0;
    w_blank_cur = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_an_sel[i] = 1'b1;
        w_digit     = r_sh_bcd[4*i +: 4];
        w_dp        = r_sh_dp[i];
        w_blank_cur = w_blank[i];
      end
    end
  end

  // A blanked digit keeps its decimal point; the anode stays driven even if
  // everything ends up dark.
  assign w_base = seg_base(w_digit);
  assign w_seg  = {(w_blank_cur ? 7'h7F : w_base[7:1]), ~w_dp};

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (&r_presc) begin
        if (r_idx == IDX_W'(N_DIGITS - 1)) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Shadow registers; the display reads only these.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_bcd <= '0;
      r_sh_dp  <= '0;
    end else if (load) begin
      r_sh_bcd <= bcd;
      r_sh_dp  <= dp;
    end
  end

  // an and seg share one register stage so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else if (!disp_en || !w_active) begin
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~w_an_sel;
      r_seg <= w_seg;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_display_mux_n_digit.sv
// -----------------------------------------------------------------------------
// tb_display_mux_n_digit
//
// Directed bench for display_mux_n_digit with N_DIGITS=4, DIV_BITS=4,
// BRIGHT_BITS=2 (16-cycle slots, 4-cycle PWM phases). Inputs are driven on
// the falling edge and outputs are sampled on the falling edge. k counts
// rising edges since reset release; the output seen after edge k reflects
// prescaler value (k-1) mod 16 and digit ((k-1)/16) mod 4.
// -----------------------------------------------------------------------------
module tb_display_mux_n_digit;

  logic        clk;
  logic        reset;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic        disp_en;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_cmp;
  int n_bad;
  int k;

  display_mux_n_digit #(
    .N_DIGITS    (4),
    .DIV_BITS    (4),
    .BRIGHT_BITS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd        (bcd),
    .dp         (dp),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .disp_en    (disp_en),
    .seg        (seg),
    .an         (an)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic goto(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    n_cmp++;
    assert ({an, seg} === {exp_an, exp_seg}) else begin
      n_bad++;
      $error("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", tag, an, seg, exp_an, exp_seg);
    end
  endtask

  task automatic check_count(input string tag, input int got, input int exp_cnt);
    n_cmp++;
    assert (got === exp_cnt) else begin
      n_bad++;
      $error("FAIL %s: count=%0d, expected %0d", tag, got, exp_cnt);
    end
  endtask

  initial begin
    int cnt;
    n_cmp = 0;
    n_bad = 0;
    k     = 0;

    // Reset held for two edges; load asserted with data to show reset wins.
    reset      = 1'b1;
    bcd        = 16'hFFFF;
    dp         = 4'hF;
    load       = 1'b1;
    blank_lz   = 1'b0;
    brightness = 2'd3;
    disp_en    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 4'b1111, 8'hFF);
    reset = 1'b0;
    load  = 1'b0;

    // Idle after reset: digit 0 of an all-zero shadow.
    goto(1);
    check("idle_digit0", 4'b1110, 8'h03);

    // Scan order with 4321.
    bcd  = 16'h4321;
    dp   = 4'b0000;
    load = 1'b1;
    goto(2);
    load = 1'b0;
    goto(3);
    check("scan_d0_start", 4'b1110, 8'h9F);
    goto(16);
    check("scan_d0_end", 4'b1110, 8'h9F);
    goto(17);
    check("scan_d1", 4'b1101, 8'h25);
    goto(33);
    check("scan_d2", 4'b1011, 8'h0D);
    goto(49);
    check("scan_d3", 4'b0111, 8'h99);
    goto(65);
    check("scan_wrap", 4'b1110, 8'h9F);

    // Double buffering: bcd changes without load are invisible.
    goto(70);
    bcd = 16'h9999;
    goto(72);
    check("no_load_hold", 4'b1110, 8'h9F);
    bcd  = 16'h00A5;
    dp   = 4'b0010;
    load = 1'b1;
    goto(73);
    load = 1'b0;
    goto(74);
    check("load_d0_5", 4'b1110, 8'h49);
    goto(81);
    check("load_d1_A_dp", 4'b1101, 8'h10);
    goto(97);
    check("zero_unblanked", 4'b1011, 8'h03);

    // Leading-zero blanking with 0070.
    bcd      = 16'h0070;
    dp       = 4'b0000;
    load     = 1'b1;
    blank_lz = 1'b1;
    goto(98);
    load = 1'b0;
    goto(100);
    check("lz_d2_blank", 4'b1011, 8'hFF);
    goto(113);
    check("lz_d3_blank", 4'b0111, 8'hFF);
    goto(129);
    check("lz_d0_zero", 4'b1110, 8'h03);
    goto(145);
    check("lz_d1_seven", 4'b1101, 8'h1F);

    // All-zero shadow: only digit 0 shows.
    bcd  = 16'h0000;
    load = 1'b1;
    goto(146);
    load = 1'b0;
    goto(150);
    check("lz0_d1_blank", 4'b1101, 8'hFF);
    goto(161);
    check("lz0_d2_blank", 4'b1011, 8'hFF);
    goto(177);
    check("lz0_d3_blank", 4'b0111, 8'hFF);
    goto(193);
    check("lz0_d0_shown", 4'b1110, 8'h03);

    // A blanked digit still shows its decimal point.
    dp   = 4'b0100;
    load = 1'b1;
    goto(194);
    load = 1'b0;
    goto(225);
    check("blank_dp_lit", 4'b1011, 8'hFE);

    // Brightness 0: 4 of 16 cycles in digit 3's slot (k=241..256).
    brightness = 2'd0;
    goto(240);
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      goto(k + 1);
      if (an == 4'b0111) cnt++;
      if (k == 244) check("bright0_last_on", 4'b0111, 8'hFF);
      if (k == 245) check("bright0_first_off", 4'b1111, 8'hFF);
    end
    check_count("bright0_duty", cnt, 4);

    // Brightness 2: 12 of 16 cycles in digit 0's slot (k=257..272).
    brightness = 2'd2;
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      goto(k + 1);
      if (an == 4'b1110 && seg == 8'h03) cnt++;
    end
    check_count("bright2_duty", cnt, 12);

    // disp_en = 0: anodes off for the whole of digit 1's slot.
    disp_en = 1'b0;
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      goto(k + 1);
      if (an == 4'b1111 && seg == 8'hFF) cnt++;
    end
    check_count("disp_off", cnt, 16);

    // Re-enable resumes mid-scan on digit 2.
    disp_en    = 1'b1;
    brightness = 2'd3;
    goto(289);
    check("reenable_d2", 4'b1011, 8'hFE);

    // Reset mid-slot on digit 2 clears the shadow and restarts the scan.
    bcd      = 16'h8888;
    dp       = 4'b1111;
    load     = 1'b1;
    blank_lz = 1'b0;
    goto(290);
    load = 1'b0;
    goto(292);
    check("pre_reset_d2", 4'b1011, 8'h00);
    goto(294);
    reset = 1'b1;
    goto(295);
    check("mid_reset", 4'b1111, 8'hFF);
    reset = 1'b0;
    goto(296);
    check("post_reset_d0", 4'b1110, 8'h03);
    goto(311);
    check("post_reset_full_slot", 4'b1110, 8'h03);
    goto(312);
    check("post_reset_d1", 4'b1101, 8'h03);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
